// File: rtl/oven_pkg.sv
// rtl/oven_pkg.sv - shared segment constants, decode table and digit-select type
package oven_pkg;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    typedef enum logic {
        ONES = 1'b0,
        TENS = 1'b1
    } digit_sel_e;

    // Active-low {g,f,e,d,c,b,a}; anything outside 0-9 shows a dash.
    function automatic logic [6:0] bcd_seg(input logic [3:0] nibble);
        logic [6:0] s;
        case (nibble)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD nibble to active-low segment decoder
module bcd_to_seg7
    import oven_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = bcd_seg(nibble);

endmodule

// File: rtl/seg7_display.sv
// rtl/seg7_display.sv - two-digit multiplexed seven-segment driver with blink and leading-zero blank
module seg7_display
    import oven_pkg::*;
#(
    parameter int REFRESH_DIV = 25000,
    parameter int BLINK_TICKS = 250,
    parameter int LZ_BLANK    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] digit_time,
    input  logic       timeout,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [RW-1:0] RCNT_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_TICKS - 1);

    logic [RW-1:0] rcnt;
    logic [BW-1:0] bcnt;
    logic          phase_on;
    logic [7:0]    disp;
    digit_sel_e    sel, sel_next;

    logic          tick;
    logic          frame_start;
    logic [7:0]    cur_digits;
    logic [3:0]    nibble;
    logic [6:0]    dec_seg;
    logic          blank;

    bcd_to_seg7 u_dec (
        .nibble (nibble),
        .seg    (dec_seg)
    );

    always_comb begin
        tick        = (rcnt == RCNT_LAST);
        frame_start = tick && (sel == TENS);
        sel_next    = sel;
        if (tick) begin
            sel_next = (sel == TENS) ? ONES : TENS;
        end
        // At frame start the fresh input is shown directly, since disp updates on the same edge.
        cur_digits = frame_start ? digit_time : disp;
        nibble     = (sel_next == ONES) ? cur_digits[3:0] : cur_digits[7:4];
        // A deasserted timeout forces visibility before the phase register has cleared.
        blank      = (timeout && !phase_on) ||
                     ((sel_next == TENS) && (LZ_BLANK != 0) && (nibble == 4'd0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt     <= '0;
            sel      <= TENS;
            disp     <= 8'h00;
            bcnt     <= '0;
            phase_on <= 1'b1;
            seg      <= SEG_OFF;
            an       <= 2'b11;
        end else begin
            rcnt <= tick ? '0 : rcnt + RW'(1);
            sel  <= sel_next;
            if (frame_start) begin
                disp <= digit_time;
            end

            if (!timeout) begin
                bcnt     <= '0;
                phase_on <= 1'b1;
            end else if (tick) begin
                if (bcnt == BCNT_LAST) begin
                    bcnt     <= '0;
                    phase_on <= ~phase_on;
                end else begin
                    bcnt <= bcnt + BW'(1);
                end
            end

            if (tick) begin
                if (blank) begin
                    an  <= 2'b11;
                    seg <= SEG_OFF;
                end else begin
                    an  <= (sel_next == ONES) ? 2'b10 : 2'b01;
                    seg <= dec_seg;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_display.sv
// tb/tb_seg7_display.sv - directed self-checking bench for seg7_display
module tb_seg7_display;

    logic       clk;
    logic       rst;
    logic [7:0] digit_time;
    logic       timeout;
    logic [6:0] seg;
    logic [1:0] an;

    int checks;
    int failures;

    seg7_display #(
        .REFRESH_DIV (4),
        .BLINK_TICKS (2),
        .LZ_BLANK    (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digit_time (digit_time),
        .timeout    (timeout),
        .seg        (seg),
        .an         (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Three reset edges; returns at the negedge before the first post-release edge.
    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        step(3);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        digit_time = 8'h13;
        timeout    = 1'b0;
        reset_dut();
        for (int i = 1; i <= 3; i++) begin
            step(1);
            checks++;
            if (an !== 2'b11 || seg !== 7'h7F) begin
                failures++;
                $display("FAIL reset_off cyc%0d: an=%b seg=%h, want an=11 seg=7f", i, an, seg);
            end
        end
        step(1);
        checks++;
        if (an !== 2'b10 || seg !== 7'h30) begin
            failures++;
            $display("FAIL reset_first_tick: an=%b seg=%h, want an=10 seg=30", an, seg);
        end
    endtask

    task automatic test_scan();
        digit_time = 8'h13;
        reset_dut();
        step(4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i % 2 == 0) begin
                if (an !== 2'b10 || seg !== 7'h30) begin
                    failures++;
                    $display("FAIL scan_ones %0d: an=%b seg=%h, want an=10 seg=30", i, an, seg);
                end
            end else begin
                if (an !== 2'b01 || seg !== 7'h79) begin
                    failures++;
                    $display("FAIL scan_tens %0d: an=%b seg=%h, want an=01 seg=79", i, an, seg);
                end
            end
            step(4);
        end
    endtask

    task automatic test_lz_dash();
        digit_time = 8'h07;
        reset_dut();
        step(4);
        checks++;
        if (an !== 2'b10 || seg !== 7'h78) begin
            failures++;
            $display("FAIL lz_ones: an=%b seg=%h, want an=10 seg=78", an, seg);
        end
        step(4);
        checks++;
        if (an !== 2'b11 || seg !== 7'h7F) begin
            failures++;
            $display("FAIL lz_tens_blank: an=%b seg=%h, want an=11 seg=7f", an, seg);
        end

        digit_time = 8'h1A;
        reset_dut();
        step(4);
        checks++;
        if (an !== 2'b10 || seg !== 7'h3F) begin
            failures++;
            $display("FAIL dash_ones: an=%b seg=%h, want an=10 seg=3f", an, seg);
        end
        step(4);
        checks++;
        if (an !== 2'b01 || seg !== 7'h79) begin
            failures++;
            $display("FAIL dash_tens: an=%b seg=%h, want an=01 seg=79", an, seg);
        end
    endtask

    task automatic test_frame_latch();
        digit_time = 8'h13;
        reset_dut();
        step(4);
        digit_time = 8'h25;
        step(4);
        checks++;
        if (an !== 2'b01 || seg !== 7'h79) begin
            failures++;
            $display("FAIL latch_old_tens: an=%b seg=%h, want an=01 seg=79", an, seg);
        end
        step(4);
        checks++;
        if (an !== 2'b10 || seg !== 7'h12) begin
            failures++;
            $display("FAIL latch_new_ones: an=%b seg=%h, want an=10 seg=12", an, seg);
        end
        step(4);
        checks++;
        if (an !== 2'b01 || seg !== 7'h24) begin
            failures++;
            $display("FAIL latch_new_tens: an=%b seg=%h, want an=01 seg=24", an, seg);
        end
    endtask

    task automatic test_blink();
        // Ticks 1,2 visible; 3,4 blank; 5,6 visible (even ticks are a zero tens digit).
        digit_time = 8'h00;
        timeout    = 1'b1;
        reset_dut();
        step(4);
        checks++;
        if (an !== 2'b10 || seg !== 7'h40) begin
            failures++;
            $display("FAIL blink_t1_on: an=%b seg=%h, want an=10 seg=40", an, seg);
        end
        step(8);
        checks++;
        if (an !== 2'b11 || seg !== 7'h7F) begin
            failures++;
            $display("FAIL blink_t3_off: an=%b seg=%h, want an=11 seg=7f", an, seg);
        end
        step(8);
        checks++;
        if (an !== 2'b10 || seg !== 7'h40) begin
            failures++;
            $display("FAIL blink_t5_on: an=%b seg=%h, want an=10 seg=40", an, seg);
        end
        timeout = 1'b0;

        // Drop timeout inside the blank half: the very next tick must be visible.
        digit_time = 8'h42;
        timeout    = 1'b1;
        reset_dut();
        step(12);
        checks++;
        if (an !== 2'b11 || seg !== 7'h7F) begin
            failures++;
            $display("FAIL blink_42_t3_off: an=%b seg=%h, want an=11 seg=7f", an, seg);
        end
        step(2);
        timeout = 1'b0;
        step(2);
        checks++;
        if (an !== 2'b01 || seg !== 7'h19) begin
            failures++;
            $display("FAIL blink_drop_visible: an=%b seg=%h, want an=01 seg=19", an, seg);
        end
    endtask

    task automatic test_mid_reset();
        digit_time = 8'h13;
        timeout    = 1'b0;
        reset_dut();
        step(6);
        rst = 1'b1;
        step(1);
        checks++;
        if (an !== 2'b11 || seg !== 7'h7F) begin
            failures++;
            $display("FAIL midrst_off: an=%b seg=%h, want an=11 seg=7f", an, seg);
        end
        rst = 1'b0;
        step(3);
        checks++;
        if (an !== 2'b11 || seg !== 7'h7F) begin
            failures++;
            $display("FAIL midrst_still_off: an=%b seg=%h, want an=11 seg=7f", an, seg);
        end
        step(1);
        checks++;
        if (an !== 2'b10 || seg !== 7'h30) begin
            failures++;
            $display("FAIL midrst_first_tick: an=%b seg=%h, want an=10 seg=30", an, seg);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        digit_time = 8'h00;
        timeout    = 1'b0;
        test_reset();
        test_scan();
        test_lz_dash();
        test_frame_latch();
        test_blink();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
